// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core.
// Generates stage register enables/flushes and PC controls for load-use
// hazards, EX redirects, LSU memory waits and the debug halt drain. It also
// keeps stall/flush performance counters and a memory-timeout watchdog.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             ls_req,
  input  logic             ls_ready,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_ls_we,
  output logic             ls_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_ls_flush,
  output logic             ls_wb_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state, state_next;
  logic [15:0] wait_cnt, wait_cnt_next;
  logic [1:0]  drain_cnt, drain_cnt_next;
  logic        timeout_set;
  logic        stall_inc;
  logic        flush_inc;

  logic mem_stall;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign mem_stall = ls_req && !ls_ready;
  assign rs1_hit   = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit   = id_rs2_used && (id_rs2 == ex_rd);
  assign load_use  = ex_is_load && ex_rf_we && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

  // Stage controls by priority: reset, halted, mem stall, redirect, load-use, drain, normal
  always_comb begin
    pc_we       = 1'b1;
    pc_sel      = 1'b0;
    if_id_we    = 1'b1;
    id_ex_we    = 1'b1;
    ex_ls_we    = 1'b1;
    ls_wb_we    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_ls_flush = 1'b0;
    ls_wb_flush = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (rst) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_ls_flush = 1'b1;
      ls_wb_flush = 1'b1;
    end else if (state == ST_HALTED) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_we    = 1'b0;
      ex_ls_we    = 1'b0;
      ls_wb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_we    = 1'b0;
      ex_ls_we    = 1'b0;
      ls_wb_flush = 1'b1;
      stall_inc   = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (state == ST_DRAIN) begin
        pc_we = 1'b0;
      end else begin
        pc_sel    = 1'b1;
        flush_inc = 1'b1;
      end
    end else if (load_use) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
      stall_inc   = 1'b1;
    end else if (state == ST_DRAIN) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // Next-state logic for run / memory wait / halt drain sequencing
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    drain_cnt_next = drain_cnt;
    timeout_set    = 1'b0;
    case (state)
      ST_RUN: begin
        if (halt_req) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = 2'd0;
        end else if (mem_stall) begin
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (ls_ready) begin
          state_next     = halt_req ? ST_DRAIN : ST_RUN;
          wait_cnt_next  = 16'd0;
          drain_cnt_next = 2'd0;
        end else begin
          if (wait_cnt != 16'hFFFF) begin
            wait_cnt_next = wait_cnt + 16'd1;
          end
          if (wait_cnt >= TIMEOUT_W) begin
            timeout_set = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!mem_stall) begin
          if (drain_cnt == 2'd3) begin
            state_next = ST_HALTED;
          end else begin
            drain_cnt_next = drain_cnt + 2'd1;
          end
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State, sequencing counters, sticky flags and performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= 16'd0;
      drain_cnt   <= 2'd0;
      halted      <= 1'b0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      drain_cnt <= drain_cnt_next;
      halted    <= (state_next == ST_HALTED);
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
      if (stall_inc) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
